// File: rtl/led_pkg.sv
// Shared types and helpers for the LED indicator and the ms tick prescaler.
package led_pkg;

  typedef enum logic [1:0] {
    LED_OFF   = 2'b00,
    LED_ON    = 2'b01,
    LED_BLINK = 2'b10,
    LED_EVENT = 2'b11
  } led_mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ON   = 2'b01,
    S_GAP  = 2'b10
  } led_state_t;

  function automatic int ms2cyc(int ms, int freq_mhz);
    return ms * freq_mhz * 1000;
  endfunction

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running prescaler: one-cycle o_tick every TICK_CYC clocks, at the counter wrap.
module ms_tick_gen #(
  parameter int TICK_CYC = 25000
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);

  localparam int TW = $clog2(TICK_CYC);
  localparam logic [TW-1:0] C_LAST = TW'(TICK_CYC - 1);

  logic [TW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == C_LAST);
  assign o_tick = w_wrap;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + TW'(1);
    end
  end

endmodule

// File: rtl/led_indicator.sv
// One board LED: steady OFF/ON, fixed-rate BLINK, or EVENT mode where pulses are
// stretched to a visible on-time followed by a minimum off-gap.
module led_indicator
  import led_pkg::*;
#(
  parameter int FREQ       = 25,
  parameter int STRETCH    = 50,
  parameter int GAP        = 30,
  parameter int BLINK_HALF = 250,
  parameter int ACTIVE_LOW = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_mode,
  input  logic       i_evt,
  output logic       o_led,
  output logic       o_busy
);

  localparam int TICK_CYC = ms2cyc(1, FREQ);
  localparam int CNT_MAX  = max3(STRETCH, GAP, BLINK_HALF);
  localparam int CW       = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] C_STRETCH = CW'(STRETCH);
  localparam logic [CW-1:0] C_GAP     = CW'(GAP);
  localparam logic [CW-1:0] C_BLINK   = CW'(BLINK_HALF);
  localparam logic [CW-1:0] C_ONE     = CW'(1);
  localparam logic          C_DARK    = (ACTIVE_LOW != 0);

  logic       w_tick;
  logic       w_mode_chg;
  logic       w_term;
  led_mode_t  w_mode;
  led_mode_t  r_prev_mode;
  led_state_t r_state;
  logic [CW-1:0] r_cnt;
  logic       r_phase;
  logic       r_pend;
  logic       r_led;
  logic       r_busy;

  ms_tick_gen #(.TICK_CYC(TICK_CYC)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_tick (w_tick)
  );

  assign w_mode     = led_mode_t'(i_mode);
  assign w_mode_chg = (w_mode != r_prev_mode);
  // Last tick of the current on, gap or blink half-period.
  assign w_term     = w_tick && (r_cnt == C_ONE);

  assign o_led  = r_led;
  assign o_busy = r_busy;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_prev_mode <= LED_OFF;
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_phase     <= 1'b0;
      r_pend      <= 1'b0;
      r_led       <= C_DARK;
      r_busy      <= 1'b0;
    end else begin
      r_prev_mode <= w_mode;
      if (w_mode_chg) begin
        // Restart cleanly in the new mode; an event in this cycle is dropped.
        r_state <= S_IDLE;
        r_pend  <= 1'b0;
        r_busy  <= 1'b0;
        r_cnt   <= (w_mode == LED_BLINK) ? C_BLINK : '0;
        r_phase <= (w_mode == LED_BLINK);
        r_led   <= C_DARK ^ ((w_mode == LED_ON) || (w_mode == LED_BLINK));
      end else begin
        case (w_mode)
          LED_OFF: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_led   <= C_DARK;
          end
          LED_ON: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_led   <= ~C_DARK;
          end
          LED_BLINK: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_led   <= C_DARK ^ (w_term ? ~r_phase : r_phase);
            if (w_term) begin
              r_phase <= ~r_phase;
              r_cnt   <= C_BLINK;
            end else if (w_tick) begin
              r_cnt <= r_cnt - C_ONE;
            end
          end
          LED_EVENT: begin
            case (r_state)
              S_IDLE: begin
                if (i_evt) begin
                  r_state <= S_ON;
                  r_cnt   <= C_STRETCH;
                  r_led   <= ~C_DARK;
                  r_busy  <= 1'b1;
                end else begin
                  r_led  <= C_DARK;
                  r_busy <= 1'b0;
                end
              end
              S_ON: begin
                r_busy <= 1'b1;
                r_led  <= C_DARK ^ ~w_term;
                if (i_evt) r_pend <= 1'b1;
                if (w_term) begin
                  r_state <= S_GAP;
                  r_cnt   <= C_GAP;
                end else if (w_tick) begin
                  r_cnt <= r_cnt - C_ONE;
                end
              end
              S_GAP: begin
                if (i_evt) r_pend <= 1'b1;
                if (w_term && (r_pend || i_evt)) begin
                  r_pend  <= 1'b0;
                  r_state <= S_ON;
                  r_cnt   <= C_STRETCH;
                  r_led   <= ~C_DARK;
                  r_busy  <= 1'b1;
                end else if (w_term) begin
                  r_state <= S_IDLE;
                  r_led   <= C_DARK;
                  r_busy  <= 1'b0;
                end else begin
                  r_led  <= C_DARK;
                  r_busy <= 1'b1;
                  if (w_tick) r_cnt <= r_cnt - C_ONE;
                end
              end
              default: begin
                r_state <= S_IDLE;
                r_led   <= C_DARK;
                r_busy  <= 1'b0;
              end
            endcase
          end
          default: begin
            r_state <= S_IDLE;
            r_led   <= C_DARK;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_indicator.sv
// Bench for led_indicator: active-high and active-low instances share stimulus and are
// checked every cycle against a tick-deadline model, plus directed duration checks.
module tb_led_indicator;
  import led_pkg::*;

  localparam int TICK       = 1000;
  localparam int STRETCH    = 3;
  localparam int GAP        = 2;
  localparam int BLINK_HALF = 2;

  logic       clk;
  logic       rst_n;
  logic [1:0] i_mode;
  logic       i_evt;
  logic       o_led, o_busy;
  logic       o_led_al, o_busy_al;

  int checks = 0;
  int passes = 0;

  led_indicator #(.FREQ(1), .STRETCH(STRETCH), .GAP(GAP), .BLINK_HALF(BLINK_HALF),
                  .ACTIVE_LOW(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_mode(i_mode), .i_evt(i_evt), .o_led(o_led), .o_busy(o_busy));

  led_indicator #(.FREQ(1), .STRETCH(STRETCH), .GAP(GAP), .BLINK_HALF(BLINK_HALF),
                  .ACTIVE_LOW(1)) u_dut_al (
    .clk(clk), .rst_n(rst_n), .i_mode(i_mode), .i_evt(i_evt), .o_led(o_led_al),
    .o_busy(o_busy_al));

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act >= lo && act <= hi) passes++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_evt();
    i_evt = 1'b1;
    @(negedge clk);
    i_evt = 1'b0;
  endtask

  // Model: stretches and gaps end on a tick-count deadline; blink phase is tick count / half.
  int  m_edges, m_ticks, m_prev, m_st, m_end, m_base, m_tk;
  bit  m_pend, m_lit, m_busy;

  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      m_edges = 0; m_ticks = 0; m_prev = int'(LED_OFF); m_st = 0; m_end = 0;
      m_base = 0; m_pend = 0; m_lit = 0; m_busy = 0;
    end else begin
      m_tk = ((m_edges % TICK) == TICK - 1) ? 1 : 0;
      m_edges++;
      m_ticks += m_tk;
      if (int'(i_mode) != m_prev) begin
        m_prev = int'(i_mode);
        m_st = 0; m_pend = 0; m_base = m_ticks;
      end else if (i_mode == LED_EVENT) begin
        case (m_st)
          0: if (i_evt) begin m_st = 1; m_end = m_ticks + STRETCH; end
          1: begin
            if (i_evt) m_pend = 1;
            if (m_ticks == m_end) begin m_st = 2; m_end = m_ticks + GAP; end
          end
          default: begin
            if (i_evt) m_pend = 1;
            if (m_ticks == m_end) begin
              if (m_pend) begin m_pend = 0; m_st = 1; m_end = m_ticks + STRETCH; end
              else m_st = 0;
            end
          end
        endcase
      end
      case (i_mode)
        LED_ON:    m_lit = 1;
        LED_BLINK: m_lit = (((m_ticks - m_base) / BLINK_HALF) % 2) == 0;
        LED_EVENT: m_lit = (m_st == 1);
        default:   m_lit = 0;
      endcase
      m_busy = (i_mode == LED_EVENT) && (m_st != 0);
    end
  end

  // Scoreboard compare, every cycle on the falling edge
  always @(negedge clk) begin
    check("cyc_led", int'(o_led), int'(m_lit));
    check("cyc_led_al", int'(o_led_al), int'(!m_lit));
    check("cyc_busy", int'(o_busy), int'(m_busy));
    check("cyc_busy_al", int'(o_busy_al), int'(m_busy));
  end

  int lit_cnt, gap_cnt, rises, first_tog, last_tog, ntog, lit_seen;
  logic prev_led;

  initial begin
    rst_n = 1'b1; i_mode = LED_ON; i_evt = 1'b0;

    // 1: reset dark, ON lit exactly one cycle after release
    cyc(3);
    check("rst_led", int'(o_led), 0);
    check("rst_led_al", int'(o_led_al), 1);
    check("rst_busy", int'(o_busy), 0);
    rst_n = 1'b0;
    #1 check("release_still_dark", int'(o_led), 0);
    @(posedge clk);
    #1 check("release_on_1cyc", int'(o_led), 1);
    cyc(20);

    // 2: single event stretch then gap
    i_mode = LED_EVENT;
    cyc(3);
    pulse_evt();
    check("evt_al_inverted", int'(o_led_al), 0);
    lit_cnt = 0;
    while (o_led && o_busy && lit_cnt < 4000) begin lit_cnt++; @(negedge clk); end
    check_range("evt_lit_time", lit_cnt, 2001, 3000);
    gap_cnt = 0;
    while (!o_led && o_busy && gap_cnt < 4000) begin gap_cnt++; @(negedge clk); end
    check_range("evt_gap_time", gap_cnt, 1001, 2000);
    check("evt_busy_end", int'(o_busy), 0);
    check("evt_led_end", int'(o_led), 0);
    cyc(10);

    // 3: five events during one stretch -> two stretches
    rises = 0; prev_led = o_led;
    for (int i = 0; i < 15000; i++) begin
      i_evt = (i == 0 || i == 200 || i == 400 || i == 600 || i == 800);
      @(negedge clk);
      if (o_led && !prev_led) rises++;
      prev_led = o_led;
      if (i > 10 && !o_busy) break;
    end
    i_evt = 1'b0;
    check("multi_evt_stretches", rises, 2);
    check("multi_evt_idle", int'(o_busy), 0);

    // 4: blink, first half lit, then 2000-cycle halves
    i_mode = LED_BLINK;
    @(posedge clk);
    #1 check("blink_first_lit", int'(o_led), 1);
    @(negedge clk);
    prev_led = o_led; ntog = 0; first_tog = 0; last_tog = 0;
    for (int i = 1; i < 10000; i++) begin
      @(negedge clk);
      if (o_led != prev_led) begin
        if (ntog == 0) first_tog = i;
        else check("blink_half_period", i - last_tog, 2000);
        last_tog = i;
        ntog++;
      end
      prev_led = o_led;
    end
    check_range("blink_first_half", first_tog, 1001, 2000);
    check_range("blink_toggles", ntog, 4, 5);

    // 5: EVENT -> OFF mid-stretch with an event pending, then back to EVENT
    i_mode = LED_EVENT;
    cyc(3);
    pulse_evt();
    cyc(300);
    pulse_evt();
    cyc(100);
    i_mode = LED_OFF;
    @(posedge clk);
    #1 check("off_led", int'(o_led), 0);
    check("off_busy", int'(o_busy), 0);
    cyc(5);
    i_mode = LED_EVENT;
    lit_seen = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (o_led || o_busy) lit_seen++;
    end
    check("no_replay", lit_seen, 0);

    // 6: async reset in the middle of a stretch
    pulse_evt();
    cyc(500);
    #2 rst_n = 1'b1;
    #1 check("async_rst_led", int'(o_led), 0);
    check("async_rst_led_al", int'(o_led_al), 1);
    check("async_rst_busy", int'(o_busy), 0);
    cyc(3);
    rst_n = 1'b0;
    cyc(5);

    // Random modes and events against the model
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 2999) == 0) i_mode = 2'($urandom_range(0, 3));
      if (i % 4000 == 0) i_mode = LED_EVENT;
      i_evt = ($urandom_range(0, 799) == 0);
      @(negedge clk);
    end
    i_evt = 1'b0;
    cyc(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
